// File: rtl/clock_mode_ctrl.sv
// Mode/position controller for a digital clock: debounced buttons, 1 s tick,
// setup/alarm increment routing and selected-field blink mask.
module clock_mode_ctrl #(
    parameter int unsigned TICK_NUM  = 50000000,
    parameter int unsigned SMP_NUM   = 500000,
    parameter int unsigned BLINK_NUM = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic       i_sec_max,
    input  logic       i_min_max,
    output logic [1:0] o_mode,
    output logic [1:0] o_position,
    output logic [2:0] o_inc,
    output logic [2:0] o_alm_inc,
    output logic [5:0] o_seg_blank
);

    localparam int unsigned TW = (TICK_NUM  > 1) ? $clog2(TICK_NUM)  : 1;
    localparam int unsigned SW = (SMP_NUM   > 1) ? $clog2(SMP_NUM)   : 1;
    localparam int unsigned BW = (BLINK_NUM > 1) ? $clog2(BLINK_NUM) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_NUM - 1);
    localparam logic [SW-1:0] SMP_LAST   = SW'(SMP_NUM - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_NUM - 1);

    typedef enum logic [1:0] {CLOCK = 2'd0, SETUP = 2'd1, ALARM = 2'd2} mode_t;
    typedef enum logic [1:0] {SEC = 2'd0, MIN = 2'd1, HOUR = 2'd2} pos_t;

    logic [SW-1:0] smp_cnt;
    logic          smp_stb;
    logic [2:0]    sw_raw;
    logic [2:0]    hist_old;
    logic [2:0]    hist_new;
    logic [2:0]    press;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          clr_tick;

    logic [BW-1:0] blink_cnt;
    logic          phase_q;
    logic          phase_d;

    mode_t mode_q, mode_d;
    pos_t  pos_q, pos_d;
    logic [2:0] inc_d;
    logic [2:0] alm_d;
    logic [5:0] blank_d;
    logic [2:0] sel;

    assign smp_stb = (smp_cnt == SMP_LAST);
    assign sw_raw  = {i_sw2, i_sw1, i_sw0};
    assign tick    = (tick_cnt == TICK_LAST);
    assign phase_d = (blink_cnt == BLINK_LAST) ? ~phase_q : phase_q;
    assign sel     = 3'b001 << pos_q;

    // A press is a 1 -> 0 -> 0 sample history; a held button never re-arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt  <= '0;
            hist_old <= '1;
            hist_new <= '1;
            press    <= '0;
        end else begin
            press   <= '0;
            smp_cnt <= smp_stb ? '0 : smp_cnt + SW'(1);
            if (smp_stb) begin
                press    <= hist_old & ~hist_new & ~sw_raw;
                hist_old <= hist_new;
                hist_new <= sw_raw;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            blink_cnt <= '0;
            phase_q   <= 1'b0;
        end else begin
            tick_cnt  <= (clr_tick || tick) ? '0 : tick_cnt + TW'(1);
            blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
            phase_q   <= phase_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= CLOCK;
            pos_q       <= SEC;
            o_inc       <= '0;
            o_alm_inc   <= '0;
            o_seg_blank <= '0;
        end else begin
            mode_q      <= mode_d;
            pos_q       <= pos_d;
            o_inc       <= inc_d;
            o_alm_inc   <= alm_d;
            o_seg_blank <= blank_d;
        end
    end

    // sw0 pre-empts sw1/sw2; increments use the position held before any advance.
    always_comb begin
        mode_d   = mode_q;
        pos_d    = pos_q;
        clr_tick = 1'b0;
        inc_d    = '0;
        alm_d    = '0;
        blank_d  = '0;

        unique case (mode_q)
            CLOCK: begin
                if (tick)
                    inc_d = {i_sec_max & i_min_max, i_sec_max, 1'b1};
                if (press[0])
                    mode_d = SETUP;
            end
            SETUP: begin
                if (press[0]) begin
                    mode_d   = ALARM;
                    clr_tick = 1'b1;
                end else if (press[2]) begin
                    inc_d = sel;
                end
            end
            ALARM: begin
                if (tick)
                    inc_d = {i_sec_max & i_min_max, i_sec_max, 1'b1};
                if (press[0])
                    mode_d = CLOCK;
                else if (press[2])
                    alm_d = sel;
            end
            default: mode_d = CLOCK;
        endcase

        if (press[0]) begin
            pos_d = SEC;
        end else if (press[1] && (mode_q != CLOCK)) begin
            unique case (pos_q)
                SEC:     pos_d = MIN;
                MIN:     pos_d = HOUR;
                default: pos_d = SEC;
            endcase
        end

        if ((mode_d != CLOCK) && phase_d)
            blank_d = 6'b000011 << {pos_d, 1'b0};
    end

    assign o_mode     = mode_q;
    assign o_position = pos_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Randomized scoreboard bench for clock_mode_ctrl against an event-level reference model.
module tb_clock_mode_ctrl;

    localparam int unsigned TICK  = 10;
    localparam int unsigned SMP   = 2;
    localparam int unsigned BLINK = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [2:0] sw      = 3'b111;
    logic       sec_max = 1'b0;
    logic       min_max = 1'b0;
    logic       rand_max = 1'b0;

    logic [1:0] o_mode;
    logic [1:0] o_position;
    logic [2:0] o_inc;
    logic [2:0] o_alm_inc;
    logic [5:0] o_seg_blank;

    clock_mode_ctrl #(
        .TICK_NUM (TICK),
        .SMP_NUM  (SMP),
        .BLINK_NUM(BLINK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_sw0      (sw[0]),
        .i_sw1      (sw[1]),
        .i_sw2      (sw[2]),
        .i_sec_max  (sec_max),
        .i_min_max  (min_max),
        .o_mode     (o_mode),
        .o_position (o_position),
        .o_inc      (o_inc),
        .o_alm_inc  (o_alm_inc),
        .o_seg_blank(o_seg_blank)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  inc;
        logic [2:0]  alm;
    } ev_t;
    ev_t sbq[$];

    // Reference model state: counts in clock edges since reset release.
    int unsigned edges;
    int unsigned since;
    int          m_mode;
    int          m_pos;
    bit          smp_hist[3][2];
    bit          pend[3];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        edges  = 0;
        since  = 0;
        m_mode = 0;
        m_pos  = 0;
        for (int i = 0; i < 3; i++) begin
            smp_hist[i][0] = 1'b1;
            smp_hist[i][1] = 1'b1;
            pend[i] = 1'b0;
        end
        sbq.delete();
    endtask

    initial begin
        bit         tick, p0, p1, p2, cur;
        logic [2:0] inc, alm, bump;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                edges++;
                tick = ((since % TICK) == TICK - 1);
                p0 = pend[0];
                p1 = pend[1] && !p0;
                p2 = pend[2] && !p0;
                bump = 3'(1 << m_pos);
                inc = '0;
                alm = '0;
                if (m_mode != 1 && tick)
                    inc = {sec_max && min_max, sec_max, 1'b1};
                if (m_mode == 1 && p2) inc = bump;
                if (m_mode == 2 && p2) alm = bump;
                since++;
                if (p0) begin
                    if (m_mode == 1) since = 0;
                    m_mode = (m_mode + 1) % 3;
                    m_pos  = 0;
                end else if (p1 && m_mode != 0) begin
                    m_pos = (m_pos + 1) % 3;
                end
                for (int i = 0; i < 3; i++) begin
                    pend[i] = 1'b0;
                    if (edges % SMP == 0) begin
                        cur = sw[i];
                        pend[i] = smp_hist[i][0] && !smp_hist[i][1] && !cur;
                        smp_hist[i][0] = smp_hist[i][1];
                        smp_hist[i][1] = cur;
                    end
                end
                if (inc != 0 || alm != 0)
                    sbq.push_back('{cyc: edges, inc: inc, alm: alm});
            end
        end
    end

    initial begin
        ev_t e;
        int  exp_blank;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_blank = (m_mode != 0 && ((edges / BLINK) % 2) == 1) ? (3 << (2 * m_pos)) : 0;
                check("mode", int'(o_mode), m_mode);
                check("position", int'(o_position), m_pos);
                check("seg_blank", int'(o_seg_blank), exp_blank);
                if (o_inc != 0 || o_alm_inc != 0) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse: got inc=%b alm=%b expected none at cycle %0d",
                                 o_inc, o_alm_inc, edges);
                    end else begin
                        e = sbq.pop_front();
                        check("pulse_cycle", int'(edges), int'(e.cyc));
                        check("inc", int'(o_inc), int'(e.inc));
                        check("alm_inc", int'(o_alm_inc), int'(e.alm));
                    end
                end
                while (sbq.size() != 0 && sbq[0].cyc < edges) begin
                    e = sbq.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missed_pulse: got none expected inc=%b alm=%b at cycle %0d",
                             e.inc, e.alm, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rand_max) begin
            #1;
            sec_max = ($urandom_range(0, 2) == 0);
            min_max = ($urandom_range(0, 1) == 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] mask, input int hold, input int gap);
        @(negedge clk); #2;
        sw = ~mask;
        idle(hold);
        #2;
        sw = 3'b111;
        idle(gap);
    endtask

    task automatic check_reset_outputs();
        check("rst_mode", int'(o_mode), 0);
        check("rst_position", int'(o_position), 0);
        check("rst_inc", int'(o_inc), 0);
        check("rst_alm_inc", int'(o_alm_inc), 0);
        check("rst_seg_blank", int'(o_seg_blank), 0);
    endtask

    initial begin
        idle(3);
        check_reset_outputs();
        #2 rst_n = 1'b1;

        idle(22);
        sec_max = 1'b1;
        idle(10);
        min_max = 1'b1;
        idle(10);
        sec_max = 1'b0;
        min_max = 1'b0;

        press(3'b001, 20, 12);
        press(3'b010, 6, 4);
        press(3'b100, 6, 4);
        press(3'b010, 6, 4);
        press(3'b010, 6, 4);
        press(3'b010, 6, 4);
        press(3'b001, 6, 4);
        press(3'b010, 6, 4);
        press(3'b010, 6, 4);
        press(3'b100, 6, 25);
        press(3'b001, 6, 14);

        press(3'b001, 6, 6);
        press(3'b101, 6, 8);
        press(3'b110, 6, 8);
        press(3'b100, 5, 7);

        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk); #2;
        rst_n = 1'b1;
        idle(25);

        rand_max = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7))
                                            : 3'(1 << $urandom_range(0, 2));
            press(m, $urandom_range(1, 12), $urandom_range(1, 10));
            if (n == 150) begin
                @(negedge clk); #2;
                sw = 3'b110;
                idle(3);
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                @(negedge clk); #2;
                rst_n = 1'b1;
                idle(10);
                #2;
                sw = 3'b111;
                idle(4);
            end
        end
        rand_max = 1'b0;
        idle(30);

        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL pending_pulses: got %0d outstanding expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 Parameter TICK_NUM, default 50000000, clk cycles per 1 s time tick.
REQ-002 Parameter SMP_NUM, default 500000, clk cycles per switch sample (100 Hz).
REQ-003 Parameter BLINK_NUM, default 25000000, clk cycles per blink phase.
REQ-004 clk  in  1  system clock, 50 MHz; sole clock, every flop on posedge clk.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_sw0 / i_sw1 / i_sw2  in  1 each  raw buttons, active-low: mode / position / increment.
REQ-007 i_sec_max  in  1  seconds counter currently at 59.
REQ-008 i_min_max  in  1  minutes counter currently at 59.
REQ-009 o_mode  out  2  0=CLOCK, 1=SETUP, 2=ALARM.
REQ-010 o_position  out  2  0=SEC, 1=MIN, 2=HOUR.
REQ-011 o_inc  out  3  one-cycle time-counter enables {hour,min,sec}.
REQ-012 o_alm_inc  out  3  one-cycle alarm-counter enables {hour,min,sec}.
REQ-013 o_seg_blank  out  6  digit blank mask: [1:0] sec, [3:2] min, [5:4] hour.

Function
REQ-014 Each switch SHALL be sampled every SMP_NUM clk; one-cycle press pulse when two consecutive samples read 0 and the sample before them read 1; held button yields exactly one pulse.
REQ-015 Mode FSM SHALL advance CLOCK->SETUP->ALARM->CLOCK on each sw0 pulse; o_mode is a registered state.
REQ-016 o_position SHALL advance SEC->MIN->HOUR->SEC on each sw1 pulse in SETUP or ALARM; ignored in CLOCK.
REQ-017 o_position SHALL return to SEC on every mode transition.
REQ-018 Tick counter SHALL count 0..TICK_NUM-1 and wrap; tick pulse at count TICK_NUM-1.
REQ-019 In CLOCK and ALARM, tick SHALL assert o_inc[0]; o_inc[1] same cycle iff i_sec_max; o_inc[2] same cycle iff i_sec_max and i_min_max.
REQ-020 In SETUP, ticks SHALL be suppressed; a sw2 pulse asserts only the o_inc bit selected by o_position, no carry.
REQ-021 In ALARM, a sw2 pulse SHALL assert only the o_alm_inc bit selected by o_position; time keeps running.
REQ-022 In CLOCK, sw2 pulses SHALL be ignored; o_alm_inc is 0 outside ALARM.
REQ-023 Tick counter SHALL clear to 0 on the SETUP->ALARM transition, so the first tick after setup is a full TICK_NUM later.
REQ-024 Simultaneous pulses: sw0 wins; sw1/sw2 pulses in that cycle are dropped. sw1 and sw2 together: increment applies to the old position, then position advances.
REQ-025 Tick and sw2 in the same ALARM cycle SHALL both take effect (separate outputs).
REQ-026 Blink phase SHALL toggle every BLINK_NUM clk; in SETUP/ALARM with phase=1, o_seg_blank SHALL set the two bits of the selected field; otherwise 0.
REQ-027 All outputs SHALL be registered; o_inc/o_alm_inc are 1 for exactly one clk per event, latency one clk after the tick or press pulse.

Reset
REQ-028 rst_n low SHALL immediately force o_mode=CLOCK, o_position=SEC, o_inc=0, o_alm_inc=0, o_seg_blank=0, all counters, samplers (to 1) and blink phase to 0.
REQ-029 Reset asserted mid-press or mid-tick SHALL discard the pending event; after release, the first tick comes TICK_NUM clk later.

Verification (TICK_NUM=10, SMP_NUM=2, BLINK_NUM=4)
REQ-030 Reset release, no buttons -> o_inc=3'b001 pulse every 10 clk; i_sec_max=1 -> 3'b011; both max -> 3'b111.
REQ-031 sw0 held low for 20 clk -> o_mode 0->1 exactly once; ticks stop; o_seg_blank toggles 6'b000011/0 every 4 clk.
REQ-032 In SETUP, sw1 press then sw2 press -> o_position=1, single o_inc=3'b010 pulse; three sw1 presses from SEC wrap to SEC.
REQ-033 In ALARM at HOUR, sw2 press -> o_alm_inc=3'b100 once, ticks continue on o_inc[0]; next sw0 -> CLOCK, o_position=0.
REQ-034 sw0 and sw2 pulses aligned in SETUP -> mode becomes ALARM, no o_inc/o_alm_inc pulse.
REQ-035 rst_n low for 1 clk mid-operation in ALARM -> all outputs 0 asynchronously, o_mode=CLOCK.
